// File: rtl/sad_column_feeder.sv
// sad_column_feeder
// Collects one NROWS x NCOLS block of per-pixel mismatch bits (row_cur ^ row_ref),
// one row per accepted handshake, then streams the block out column by column so
// that each column is the NROWS-bit input vector of the column tree adder.
// Single-buffered: the block is either filling (rows in) or draining (columns out).
//
// Ports:
//   clk        single clock
//   rst        asynchronous, active-high reset; discards any partial block
//   row_valid  input row present
//   row_ready  block can accept a row (high only while filling)
//   row_cur    current-frame bits of one row, bit c is column c
//   row_ref    reference-frame bits of the same row
//   col_valid  output column present (high only while draining)
//   col_ready  downstream accepts the column
//   col_data   column bits, bit r is the mismatch bit of row r
//   col_idx    index of the column currently presented
//   col_last   high with col_valid on the final column of the block
module sad_column_feeder #(
   parameter int unsigned NROWS  = 100,
   parameter int unsigned NCOLS  = 16,
   parameter int unsigned RIDX_W = $clog2(NROWS),
   parameter int unsigned CIDX_W = $clog2(NCOLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              row_valid,
   output logic              row_ready,
   input  logic [NCOLS-1:0]  row_cur,
   input  logic [NCOLS-1:0]  row_ref,
   output logic              col_valid,
   input  logic              col_ready,
   output logic [NROWS-1:0]  col_data,
   output logic [CIDX_W-1:0] col_idx,
   output logic              col_last
);

   typedef enum logic [0:0] {StFill, StDrain} state_e;

   state_e            state_q, state_d;
   logic [RIDX_W-1:0] row_cnt_q, row_cnt_d;
   logic [CIDX_W-1:0] col_cnt_q, col_cnt_d;
   logic [NCOLS-1:0]  mem_q [NROWS];
   logic [NCOLS-1:0]  row_xor;
   logic              row_fire;

   assign row_xor = row_cur ^ row_ref;

   // State, counters and mismatch array. The array is cleared on reset so a
   // discarded block can never leak into col_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StFill;
         row_cnt_q <= '0;
         col_cnt_q <= '0;
         for (int r = 0; r < NROWS; r++) begin
            mem_q[r] <= '0;
         end
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         if (row_fire) begin
            mem_q[row_cnt_q] <= row_xor;
         end
      end
   end

   // Next state, counter updates and handshake outputs.
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      row_ready = 1'b0;
      col_valid = 1'b0;
      row_fire  = 1'b0;
      case (state_q)
         StFill: begin
            row_ready = 1'b1;
            if (row_valid) begin
               row_fire = 1'b1;
               if (row_cnt_q == RIDX_W'(NROWS - 1)) begin
                  row_cnt_d = '0;
                  col_cnt_d = '0;
                  state_d   = StDrain;
               end else begin
                  row_cnt_d = row_cnt_q + 1'b1;
               end
            end
         end
         StDrain: begin
            col_valid = 1'b1;
            if (col_ready) begin
               if (col_cnt_q == CIDX_W'(NCOLS - 1)) begin
                  col_cnt_d = '0;
                  state_d   = StFill;
               end else begin
                  col_cnt_d = col_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   // Column c is bit c of every stored row; held stable by col_cnt while stalled.
   always_comb begin
      col_data = '0;
      for (int r = 0; r < NROWS; r++) begin
         col_data[r] = mem_q[r][col_cnt_q];
      end
   end

   assign col_idx  = col_cnt_q;
   assign col_last = col_valid && (col_cnt_q == CIDX_W'(NCOLS - 1));

endmodule
